// File: rtl/bicubic_pkg.sv
// Shared types, widths and boundary-index helper for the bicubic tap fetcher.
// Build option: BICUBIC_FETCH_MIRROR_EN selects mirror instead of clamp at row edges.
package bicubic_pkg;
  localparam int Q08_W = 8;
  localparam int Q88_W = 16;
  localparam int TAP_W = 10;
  localparam logic [Q08_W-1:0] ONE_Q08 = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PRESENT, ST_DONE} state_e;

  // Map a signed tap index onto a valid pixel of a row of width sw (sw >= 1).
  function automatic logic [Q08_W-1:0] tap_idx(input logic signed [TAP_W-1:0] t,
                                               input logic [Q08_W-1:0] sw);
    logic signed [TAP_W-1:0] hi;
    logic signed [TAP_W-1:0] m;
    hi = $signed({2'b00, sw}) - 10'sd1;
`ifdef BICUBIC_FETCH_MIRROR_EN
    if (t < 0)       m = -t;
    else if (t > hi) m = (hi <<< 1) - t;
    else             m = t;
`else
    m = t;
`endif
    // final clamp also catches mirrored indices that still fall off tiny rows
    if (m < 0)       tap_idx = '0;
    else if (m > hi) tap_idx = 8'(hi);
    else             tap_idx = 8'(m);
  endfunction
endpackage

// File: rtl/bicubic_frac_pow.sv
// Sequential fraction powers: x^2 then x^3, round-half-up, one shared 8x8 multiplier.
// start in cycle 0 registers x^2; cycle 1 registers x^3 and raises ready.
module bicubic_frac_pow
  import bicubic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Q08_W-1:0] x,
  output logic [Q08_W-1:0] x2,
  output logic [Q08_W-1:0] x3,
  output logic             ready
);
  logic             ph_q;
  logic             rdy_q;
  logic [Q08_W-1:0] x2_q;
  logic [Q08_W-1:0] x3_q;
  logic [Q08_W-1:0] a;
  logic [15:0]      mul;
  logic [Q08_W-1:0] res;

  assign a   = ph_q ? x2_q : x;
  assign mul = a * x;
  assign res = 8'((32'(mul) + 32'd128) >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= 1'b0;
      rdy_q <= 1'b0;
      x2_q  <= '0;
      x3_q  <= '0;
    end else if (start) begin
      x2_q  <= res;
      ph_q  <= 1'b1;
      rdy_q <= 1'b0;
    end else if (ph_q) begin
      x3_q  <= res;
      ph_q  <= 1'b0;
      rdy_q <= 1'b1;
    end
  end

  assign x2    = x2_q;
  assign x3    = x3_q;
  assign ready = rdy_q;
endmodule

// File: rtl/bicubic_tap_fetch.sv
// Row walker feeding the bicubic core: 4 ROM taps plus fraction powers per output pixel.
// Edge handling is clamp by default, mirror when BICUBIC_FETCH_MIRROR_EN is defined.
module bicubic_tap_fetch
  import bicubic_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int POS_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        src_w,
  input  logic [7:0]        dst_w,
  input  logic [POS_W-1:0]  step,
  input  logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [7:0]        p0,
  output logic [7:0]        p1,
  output logic [7:0]        p2,
  output logic [7:0]        p3,
  output logic [7:0]        x_vec0,
  output logic [7:0]        x_vec1,
  output logic [7:0]        x_vec2,
  output logic [7:0]        x_vec3,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic              busy,
  output logic              done
);
  state_e             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               latch, fp_start;

  logic [7:0]         sw_q, dw_q;
  logic [POS_W-1:0]   step_q;
  logic [ADDR_W-1:0]  base_q, addr_q, addr_c;
  logic [3:0][7:0]    p_q;
  logic [3:0][7:0]    xv_q;

  logic [7:0]         fp_x2, fp_x3;
  logic               fp_rdy;
  logic signed [TAP_W-1:0] t;

  bicubic_frac_pow u_pow (
    .clk   (clk),
    .rst   (rst),
    .start (fp_start),
    .x     (pos_q[7:0]),
    .x2    (fp_x2),
    .x3    (fp_x3),
    .ready (fp_rdy)
  );

  // tap k of the current pixel sits at integer part - 1 + k
  assign t      = $signed({2'b00, pos_q[POS_W-1 -: 8]}) + $signed({7'b0, k_q}) - 10'sd1;
  assign addr_c = base_q + ADDR_W'(tap_idx(t, sw_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    fp_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dst_w != 8'd0) begin
            latch   = 1'b1;
            pos_d   = '0;
            cnt_d   = '0;
            k_d     = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        fp_start = (k_q == 3'd0);
        if (k_q == 3'd4) begin
          if (fp_rdy) state_d = ST_PRESENT;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_PRESENT: begin
        if (tap_ready) begin
          cnt_d = cnt_q + 8'd1;
          pos_d = pos_q + step_q;
          k_d   = '0;
          state_d = (cnt_q == dw_q - 8'd1) ? ST_DONE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q   <= '0;
      dw_q   <= '0;
      step_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      p_q    <= '0;
      xv_q   <= '0;
    end else begin
      if (latch) begin
        sw_q   <= src_w;
        dw_q   <= dst_w;
        step_q <= step;
        base_q <= row_base;
      end
      if (state_q == ST_FETCH) begin
        if (k_q != 3'd4) addr_q <= addr_c;
        // ROM data trails its address by one cycle
        if (k_q != 3'd0) p_q[k_q[1:0] - 2'd1] <= rom_q;
        if (k_q == 3'd4 && fp_rdy) begin
          xv_q[0] <= fp_x3;
          xv_q[1] <= fp_x2;
          xv_q[2] <= pos_q[7:0];
          xv_q[3] <= ONE_Q08;
        end
      end
    end
  end

  assign rom_addr  = (state_q == ST_FETCH && k_q != 3'd4) ? addr_c : addr_q;
  assign p0        = p_q[0];
  assign p1        = p_q[1];
  assign p2        = p_q[2];
  assign p3        = p_q[3];
  assign x_vec0    = xv_q[0];
  assign x_vec1    = xv_q[1];
  assign x_vec2    = xv_q[2];
  assign x_vec3    = xv_q[3];
  assign tap_valid = (state_q == ST_PRESENT);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_PRESENT);
  assign done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_bicubic_tap_fetch.sv
// Scoreboard bench for bicubic_tap_fetch: directed rows, expected taps queued at issue.
module tb_bicubic_tap_fetch;
`ifdef BICUBIC_FETCH_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  src_w = '0, dst_w = '0;
  logic [15:0] step = '0;
  logic [13:0] row_base = '0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_q = '0;
  logic [7:0]  p0, p1, p2, p3, x_vec0, x_vec1, x_vec2, x_vec3;
  logic        tap_valid, busy, done;
  logic        tap_ready = 1'b1;
  logic [7:0]  rom [0:255];

  typedef struct packed {
    logic [7:0] p0, p1, p2, p3, x0, x1, x2, x3;
    logic [13:0] a;
  } tap_t;

  tap_t  exp_q[$];
  int    exp_done = 0;
  int    checks = 0;
  int    errors = 0;
  tap_t  act, e;
  logic [80:0] outs;

  bicubic_tap_fetch dut (
    .clk(clk), .rst(rst), .start(start), .src_w(src_w), .dst_w(dst_w), .step(step),
    .row_base(row_base), .rom_addr(rom_addr), .rom_q(rom_q),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .x_vec0(x_vec0), .x_vec1(x_vec1), .x_vec2(x_vec2), .x_vec3(x_vec3),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr[7:0]];

  assign act  = {p0, p1, p2, p3, x_vec0, x_vec1, x_vec2, x_vec3, rom_addr};
  assign outs = {rom_addr, p0, p1, p2, p3, x_vec0, x_vec1, x_vec2, x_vec3, tap_valid, busy, done};

  function automatic tap_t mk(input logic [31:0] p, input logic [23:0] x, input logic [13:0] a);
    mk = {p, x, 8'hFF, a};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic push(input tap_t c, input tap_t m);
    exp_q.push_back(MIR ? m : c);
  endtask

  task automatic go(input logic [7:0] sw, input logic [7:0] dw, input logic [15:0] stp,
                    input logic [13:0] base);
    @(posedge clk); #1;
    src_w = sw; dst_w = dw; step = stp; row_base = base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      got = done;
    end
    chk("done_seen", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic seen;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h3E; rom[1] = 8'h17; rom[2] = 8'h55; rom[3] = 8'h2B;
    for (int j = 0; j < 8; j++) rom[16 + j] = 8'hA0 + 8'(j);

    fork
      begin
        forever begin
          @(negedge clk);
          if (tap_valid && tap_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL tap_unexpected: got %0h expected none", act);
            end else begin
              e = exp_q.pop_front();
              if (act !== e) begin
                errors++;
                $display("FAIL tap: got %0h expected %0h", act, e);
              end
            end
          end else if (tap_valid && exp_q.size() != 0) begin
            checks++;
            if (act !== exp_q[0]) begin
              errors++;
              $display("FAIL tap_stall_stable: got %0h expected %0h", act, exp_q[0]);
            end
          end
          if (done) begin
            checks++;
            if (exp_done == 0) begin
              errors++;
              $display("FAIL done_unexpected: got 1 expected 0");
            end else exp_done--;
          end
        end
      end
      begin
        #12;
        chk("reset_outputs", outs, 0);
        @(posedge clk); #1 rst = 1'b0;

        // fraction 0x80 on the second pixel
        push(mk(32'h3E3E1755, 24'h000000, 14'd2), mk(32'h173E1755, 24'h000000, 14'd2));
        push(mk(32'h3E3E1755, 24'h204080, 14'd2), mk(32'h173E1755, 24'h204080, 14'd2));
        exp_done++;
        go(8'd4, 8'd2, 16'h0080, 14'd0);
        wait_done(cyc);

        // three taps at i=0,1,3 on the row at base 16
        push(mk(32'hA0A0A1A2, 24'h000000, 14'd18), mk(32'hA1A0A1A2, 24'h000000, 14'd18));
        push(mk(32'hA0A1A2A3, 24'h204080, 14'd19), mk(32'hA0A1A2A3, 24'h204080, 14'd19));
        push(mk(32'hA2A3A4A5, 24'h000000, 14'd21), mk(32'hA2A3A4A5, 24'h000000, 14'd21));
        exp_done++;
        go(8'd8, 8'd3, 16'h0180, 14'd16);
        wait_done(cyc);

        // right edge at integer part 3
        push(mk(32'h3E3E1755, 24'h000000, 14'd2), mk(32'h173E1755, 24'h000000, 14'd2));
        push(mk(32'h552B2B2B, 24'h000000, 14'd3), mk(32'h552B5517, 24'h000000, 14'd1));
        exp_done++;
        go(8'd4, 8'd2, 16'h0300, 14'd0);
        wait_done(cyc);

        // maximum fraction
        push(mk(32'hA0A0A1A2, 24'h000000, 14'd18), mk(32'hA1A0A1A2, 24'h000000, 14'd18));
        push(mk(32'hA0A0A1A2, 24'hFDFEFF, 14'd18), mk(32'hA1A0A1A2, 24'hFDFEFF, 14'd18));
        exp_done++;
        go(8'd8, 8'd2, 16'h00FF, 14'd16);
        wait_done(cyc);

        // integer part 5 overshoots a 4-pixel row
        push(mk(32'h3E3E1755, 24'h000000, 14'd2), mk(32'h173E1755, 24'h000000, 14'd2));
        push(mk(32'h2B2B2B2B, 24'h000000, 14'd3), mk(32'h55173E3E, 24'h000000, 14'd0));
        exp_done++;
        go(8'd4, 8'd2, 16'h0500, 14'd0);
        wait_done(cyc);

        // back-pressure plus a start pulse while busy
        tap_ready = 1'b0;
        push(mk(32'hA0A0A1A2, 24'h000000, 14'd18), mk(32'hA1A0A1A2, 24'h000000, 14'd18));
        push(mk(32'hA0A1A2A3, 24'h204080, 14'd19), mk(32'hA0A1A2A3, 24'h204080, 14'd19));
        exp_done++;
        go(8'd8, 8'd2, 16'h0180, 14'd16);
        cyc = 0;
        while (!tap_valid && cyc < 50) begin
          @(negedge clk);
          cyc++;
        end
        chk("first_tap_latency", cyc, 6);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; dst_w = 8'd5; src_w = 8'd2; row_base = 14'd0;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("stall_busy_valid", {busy, tap_valid}, 2'b11);
        @(posedge clk); #1 tap_ready = 1'b1;
        wait_done(cyc);

        // asynchronous reset in the middle of FETCH
        go(8'd8, 8'd3, 16'h0180, 14'd16);
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", outs, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("after_reset_idle", outs, 0);

        push(mk(32'hA0A0A1A2, 24'h000000, 14'd18), mk(32'hA1A0A1A2, 24'h000000, 14'd18));
        push(mk(32'hA0A1A2A3, 24'h204080, 14'd19), mk(32'hA0A1A2A3, 24'h204080, 14'd19));
        push(mk(32'hA2A3A4A5, 24'h000000, 14'd21), mk(32'hA2A3A4A5, 24'h000000, 14'd21));
        exp_done++;
        go(8'd8, 8'd3, 16'h0180, 14'd16);
        wait_done(cyc);

        // empty row
        exp_done++;
        go(8'd8, 8'd0, 16'h0100, 14'd16);
        wait_done(cyc);
        chk("dw0_done_latency", cyc, 1);
        seen = 1'b0;
        repeat (8) begin
          @(negedge clk);
          seen = seen | tap_valid | busy;
        end
        chk("dw0_no_valid", seen, 0);

        chk("taps_drained", exp_q.size(), 0);
        chk("dones_drained", exp_done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end
endmodule

// File: doc/bicubic_tap_fetch.md
Name: bicubic_tap_fetch

Overview:
Upstream feeder for the bicubic interpolation core. It walks the destination pixels of one image row and keeps a Q8.8 source position for each one. For every output pixel it reads the 4 neighbouring source pixels P(-1), P(0), P(1), P(2) from a synchronous image ROM and computes the power vector of the fraction. It then presents pixels and powers to the core through a valid/ready handshake.

Parameters:
ADDR_W, 14, width of image ROM address and row_base.
POS_W, 16, source position accumulator width, Q8.8.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a row; ignored while busy
src_w  in  8  source row width in pixels (>=1)
dst_w  in  8  destination pixels to produce
step  in  POS_W  Q8.8 source increment per destination pixel
row_base  in  ADDR_W  ROM address of source pixel 0 of this row
rom_addr  out  ADDR_W  image ROM read address
rom_q  in  8  ROM data, valid 1 cycle after rom_addr
p0..p3  out  8 each  P(-1), P(0), P(1), P(2)
x_vec0..x_vec3  out  8 each  Q0.8: x³, x², x, 8'hFF (1.0)
tap_valid  out  1  taps/powers valid
tap_ready  in  1  core accepts taps
busy  out  1  row in progress
done  out  1  one-cycle pulse after last tap accepted

Behaviour:
- Reset (async): state IDLE. All outputs 0, including rom_addr, p*, x_vec*, tap_valid, busy and done. pos=0, count=0.
- IDLE:
  - start with dst_w!=0: latch src_w, dst_w, step and row_base; pos=0; count=0; busy=1; go to FETCH (k=0).
  - start with dst_w==0: done pulses the next cycle; stay IDLE.
- FETCH, k=0..4:
  - Integer part i=pos[15:8], fraction x=pos[7:0].
  - Cycles k=0..3 drive rom_addr=row_base+idx(i-1+k).
  - Cycle k>=1 captures rom_q into p(k-1).
  - Cycle 0: x2=(x*x+128)>>8 is registered. Cycle 1: x3=(x2*x+128)>>8 is registered. Both use one 8x8 multiplier.
  - At cycle k=4, go to PRESENT.
- PRESENT:
  - tap_valid=1. p*, x_vec* and rom_addr are held stable until tap_ready.
  - On tap_valid&&tap_ready: count+=1; pos+=step (wrapping mod 2^POS_W).
  - If count==dst_w-1, go to DONE; otherwise go to FETCH k=0. tap_valid drops the next cycle.
- DONE: done=1 for one cycle; busy=0; return to IDLE.
- Latency: tap_valid rises 5 clocks after FETCH entry. Row throughput is at best 6 clocks per pixel.
- idx() boundary rule (clamp): idx<0 maps to 0; idx>src_w-1 maps to src_w-1. This also covers an integer part that overshoots the row.
- x==0 gives x_vec0=x_vec1=x_vec2=0. x_vec3 is always 8'hFF.
- start during busy is ignored. Reset mid-row aborts with no done pulse.
- All arithmetic is unsigned. Tap indices use 10-bit signed intermediate values.

Optional Feature:
BICUBIC_FETCH_MIRROR_EN
- Defined: mirror boundary. idx<0 maps to -idx; idx>src_w-1 maps to 2*(src_w-1)-idx, then clamped to [0,src_w-1] (this covers src_w<3).
- Undefined: clamp boundary as above.

Decomposition:
- Package bicubic_pkg:
  - Q0.8/Q8.8 width constants.
  - ONE_Q08=8'hFF.
  - FSM state encoding (IDLE, FETCH, PRESENT, DONE).
  - Boundary index function.
- Sub-module bicubic_frac_pow:
  - Sequential x -> x², x³ with round-half-up.
  - Start/ready pins; 2-cycle latency.

Test Plan:
1. ROM[0..3]=3E,17,55,2B; src_w=4, dst_w=1, pos start forced to 0x0080 via step irrelevant (use row where j=0 plus step=0x0080, dst_w=2, check 2nd) -> second tap: p=3E,3E,17,55, x_vec=20,40,80,FF.
2. src_w=8, dst_w=3, step=0x0180 -> taps at i=0,1,3. Middle tap reads addresses base+0..3 with x=80. done pulses once after the third handshake.
3. src_w=4, integer part 3 -> p from idx 2,3,3,3 (clamp). With BICUBIC_FETCH_MIRROR_EN: idx 2,3,2,1. i=0 with mirror -> idx 1,0,1,2.
4. x=FF -> x_vec0=FD, x_vec1=FE, x_vec2=FF, x_vec3=FF.
5. tap_ready held low 10 cycles in PRESENT -> outputs and rom_addr stable, tap_valid=1, no count advance. Also: start pulsed while busy -> no effect.
6. rst asserted mid-FETCH (asynchronous, between edges) -> outputs 0 immediately, busy=0, no done. A fresh start then completes normally; dst_w=0 start -> done after 1 cycle, tap_valid never rises.
